// File: rtl/stb_fifo_bridge_pkg.sv
// Shared definitions for the STB channel FIFO bridge: control/status bit
// positions, the control byte layout and the stall watchdog reload value.
package stb_fifo_bridge_pkg;

  localparam int STB_CTRL_FLUSH_H2S = 0;
  localparam int STB_CTRL_FLUSH_S2H = 1;
  localparam int STB_CTRL_DROP_MODE = 2;
  localparam int STB_CTRL_SOC_EN    = 3;

  localparam int STB_STAT_H2S_EMPTY = 0;
  localparam int STB_STAT_H2S_FULL  = 1;
  localparam int STB_STAT_S2H_EMPTY = 2;
  localparam int STB_STAT_S2H_FULL  = 3;
  localparam int STB_STAT_H2S_OVF   = 4;
  localparam int STB_STAT_S2H_OVF   = 5;
  localparam int STB_STAT_SOC_EN    = 6;

  // Watchdog counts down from here; terminal count marks 256 stalled cycles.
  localparam logic [7:0] STB_WD_RELOAD = 8'hFF;

  // Declared MSB first so that flush_h2s lands on bit 0.
  typedef struct packed {
    logic [3:0] rsvd;
    logic       soc_enable;
    logic       drop_mode;
    logic       flush_s2h;
    logic       flush_h2s;
  } stb_ctrl_t;

endpackage

// File: rtl/stb_fifo_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO with one-shot flush; head data
// reads as zero while empty so nothing stale leaks onto the outputs.
module stb_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pop_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign do_push    = push_valid && !full;
  assign do_pop     = pop_ready && !empty;

  // Flush wins over any push on the same edge; a pop that edge has already
  // been consumed by the reader since the head is combinational.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/stb_fifo_bridge.sv
// STB channel bridge: host words flow to the SoC through h2s, SoC words flow
// back through s2h; a control byte flushes/configures, a status byte reports.
module stb_fifo_bridge
  import stb_fifo_bridge_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 8,
  parameter int STATUS_WIDTH  = 8
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     CTRL_VALID_I,
  output logic                     CTRL_READY_O,
  input  logic [CONTROL_WIDTH-1:0] CTRL_I,
  output logic                     STATUS_VALID_O,
  input  logic                     STATUS_READY_I,
  output logic [STATUS_WIDTH-1:0]  STATUS_O,
  input  logic                     HDATA_VALID_I,
  output logic                     HDATA_READY_O,
  input  logic [DATA_WIDTH-1:0]    HDATA_I,
  output logic                     HDATA_VALID_O,
  input  logic                     HDATA_READY_I,
  output logic [DATA_WIDTH-1:0]    HDATA_O,
  output logic                     SOC_VALID_O,
  input  logic                     SOC_READY_I,
  output logic [DATA_WIDTH-1:0]    SOC_DATA_O,
  input  logic                     SOC_VALID_I,
  output logic                     SOC_READY_O,
  input  logic [DATA_WIDTH-1:0]    SOC_DATA_I
);

  stb_ctrl_t  ctrl_in;
  logic       ctrl_unused;
  logic       ctrl_hs;
  logic       drop_mode;
  logic       soc_enable;
  logic       h2s_empty, h2s_full, h2s_push_ready, h2s_pop_valid;
  logic       s2h_empty, s2h_full, s2h_push_ready;
  logic       h2s_stall, h2s_ovf_ev, s2h_ovf_ev;
  logic       h2s_ovf, s2h_ovf;
  logic       stat_hs;
  logic [7:0] wd_cnt;
  logic [7:0] status_d, status_q;

  always_comb begin
    ctrl_in            = '0;
    ctrl_in.flush_h2s  = CTRL_I[STB_CTRL_FLUSH_H2S];
    ctrl_in.flush_s2h  = CTRL_I[STB_CTRL_FLUSH_S2H];
    ctrl_in.drop_mode  = CTRL_I[STB_CTRL_DROP_MODE];
    ctrl_in.soc_enable = CTRL_I[STB_CTRL_SOC_EN];
  end
  assign ctrl_unused = ^{CTRL_I[CONTROL_WIDTH-1:4], ctrl_in.rsvd};

  assign CTRL_READY_O = 1'b1;
  assign ctrl_hs      = CTRL_VALID_I;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      drop_mode  <= 1'b0;
      soc_enable <= 1'b0;
    end else if (ctrl_hs) begin
      drop_mode  <= ctrl_in.drop_mode;
      soc_enable <= ctrl_in.soc_enable;
    end
  end

  stb_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_h2s (
    .clk        (CLK_I),
    .rst        (RST_I),
    .flush      (ctrl_hs && ctrl_in.flush_h2s),
    .push_valid (HDATA_VALID_I),
    .push_ready (h2s_push_ready),
    .push_data  (HDATA_I),
    .pop_valid  (h2s_pop_valid),
    .pop_ready  (SOC_READY_I && soc_enable),
    .pop_data   (SOC_DATA_O),
    .empty      (h2s_empty),
    .full       (h2s_full)
  );

  stb_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_s2h (
    .clk        (CLK_I),
    .rst        (RST_I),
    .flush      (ctrl_hs && ctrl_in.flush_s2h),
    .push_valid (SOC_VALID_I && SOC_READY_O),
    .push_ready (s2h_push_ready),
    .push_data  (SOC_DATA_I),
    .pop_valid  (HDATA_VALID_O),
    .pop_ready  (HDATA_READY_I),
    .pop_data   (HDATA_O),
    .empty      (s2h_empty),
    .full       (s2h_full)
  );

  // Pointers clear asynchronously, but an empty FIFO still looks writable.
  assign HDATA_READY_O = h2s_push_ready && !RST_I;
  assign SOC_VALID_O   = soc_enable && h2s_pop_valid;
  assign SOC_READY_O   = soc_enable && (drop_mode || s2h_push_ready);

  // A push can only happen when not full, so any push also reloads the timer.
  assign h2s_stall  = HDATA_VALID_I && h2s_full;
  assign h2s_ovf_ev = h2s_stall && (wd_cnt == '0);
  assign s2h_ovf_ev = SOC_VALID_I && SOC_READY_O && s2h_full;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)           wd_cnt <= STB_WD_RELOAD;
    else if (!h2s_stall) wd_cnt <= STB_WD_RELOAD;
    else if (wd_cnt != '0) wd_cnt <= wd_cnt - 8'd1;
  end

  assign stat_hs = STATUS_VALID_O && STATUS_READY_I;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      h2s_ovf <= 1'b0;
      s2h_ovf <= 1'b0;
    end else begin
      h2s_ovf <= (h2s_ovf && !stat_hs) || h2s_ovf_ev;
      s2h_ovf <= (s2h_ovf && !stat_hs) || s2h_ovf_ev;
    end
  end

  always_comb begin
    status_d                     = '0;
    status_d[STB_STAT_H2S_EMPTY] = h2s_empty;
    status_d[STB_STAT_H2S_FULL]  = h2s_full;
    status_d[STB_STAT_S2H_EMPTY] = s2h_empty;
    status_d[STB_STAT_S2H_FULL]  = s2h_full;
    status_d[STB_STAT_H2S_OVF]   = h2s_ovf;
    status_d[STB_STAT_S2H_OVF]   = s2h_ovf;
    status_d[STB_STAT_SOC_EN]    = soc_enable;
  end

  // Snapshot of the state as it stood before each edge.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      status_q       <= '0;
      STATUS_VALID_O <= 1'b0;
    end else begin
      status_q       <= status_d;
      STATUS_VALID_O <= 1'b1;
    end
  end

  assign STATUS_O = STATUS_WIDTH'(status_q);

endmodule

// File: tb/tb_stb_fifo_bridge.sv
// Bench for stb_fifo_bridge: directed scenarios plus random traffic, checked
// by a queue-based reference model sampled on the falling edge.
module tb_stb_fifo_bridge;

  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b1;
  logic          CTRL_VALID_I = 1'b0;
  logic          CTRL_READY_O;
  logic [7:0]    CTRL_I = '0;
  logic          STATUS_VALID_O;
  logic          STATUS_READY_I = 1'b0;
  logic [7:0]    STATUS_O;
  logic          HDATA_VALID_I = 1'b0;
  logic          HDATA_READY_O;
  logic [DW-1:0] HDATA_I = '0;
  logic          HDATA_VALID_O;
  logic          HDATA_READY_I = 1'b0;
  logic [DW-1:0] HDATA_O;
  logic          SOC_VALID_O;
  logic          SOC_READY_I = 1'b0;
  logic [DW-1:0] SOC_DATA_O;
  logic          SOC_VALID_I = 1'b0;
  logic          SOC_READY_O;
  logic [DW-1:0] SOC_DATA_I = '0;

  always #5 CLK_I = ~CLK_I;

  stb_fifo_bridge #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .CONTROL_WIDTH(8), .STATUS_WIDTH(8)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .CTRL_VALID_I(CTRL_VALID_I), .CTRL_READY_O(CTRL_READY_O), .CTRL_I(CTRL_I),
    .STATUS_VALID_O(STATUS_VALID_O), .STATUS_READY_I(STATUS_READY_I), .STATUS_O(STATUS_O),
    .HDATA_VALID_I(HDATA_VALID_I), .HDATA_READY_O(HDATA_READY_O), .HDATA_I(HDATA_I),
    .HDATA_VALID_O(HDATA_VALID_O), .HDATA_READY_I(HDATA_READY_I), .HDATA_O(HDATA_O),
    .SOC_VALID_O(SOC_VALID_O), .SOC_READY_I(SOC_READY_I), .SOC_DATA_O(SOC_DATA_O),
    .SOC_VALID_I(SOC_VALID_I), .SOC_READY_O(SOC_READY_O), .SOC_DATA_I(SOC_DATA_I)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: queues hold expected contents, flags follow from sizes.
  logic [DW-1:0] hq[$];
  logic [DW-1:0] sq[$];
  bit            m_en, m_drop, m_hovf, m_sovf;
  int            stall_run;
  logic [7:0]    exp_stat;
  bit            exp_sv;

  always @(negedge CLK_I) begin
    bit h_push, h_pop, s_push, s_pop, s_drop, s_rdy, st_hs;
    if (RST_I) begin
      chk("rst_soc_valid", SOC_VALID_O, 0);
      chk("rst_soc_data", SOC_DATA_O, 0);
      chk("rst_soc_ready", SOC_READY_O, 0);
      chk("rst_hdata_ready", HDATA_READY_O, 0);
      chk("rst_hdata_valid", HDATA_VALID_O, 0);
      chk("rst_hdata_o", HDATA_O, 0);
      chk("rst_status_valid", STATUS_VALID_O, 0);
      chk("rst_status", STATUS_O, 0);
      hq.delete(); sq.delete();
      m_en = 0; m_drop = 0; m_hovf = 0; m_sovf = 0; stall_run = 0;
      exp_stat = '0; exp_sv = 0;
    end else begin
      s_rdy = m_en && (m_drop || sq.size() < DEPTH);
      chk("ctrl_ready", CTRL_READY_O, 1);
      chk("hdata_ready", HDATA_READY_O, hq.size() < DEPTH);
      chk("soc_valid", SOC_VALID_O, m_en && hq.size() > 0);
      if (m_en && hq.size() > 0) chk("soc_data", SOC_DATA_O, hq[0]);
      chk("hdata_valid", HDATA_VALID_O, sq.size() > 0);
      if (sq.size() > 0) chk("hdata_o", HDATA_O, sq[0]);
      chk("soc_ready", SOC_READY_O, s_rdy);
      chk("status_valid", STATUS_VALID_O, exp_sv);
      chk("status", STATUS_O, exp_stat);

      h_push = HDATA_VALID_I && hq.size() < DEPTH;
      s_pop  = m_en && hq.size() > 0 && SOC_READY_I;
      h_pop  = sq.size() > 0 && HDATA_READY_I;
      s_push = SOC_VALID_I && s_rdy && sq.size() < DEPTH;
      s_drop = SOC_VALID_I && s_rdy && sq.size() == DEPTH;
      stall_run = (HDATA_VALID_I && hq.size() == DEPTH) ? stall_run + 1 : 0;
      st_hs = exp_sv && STATUS_READY_I;

      exp_stat = {1'b0, m_en, m_sovf, m_hovf, sq.size() == DEPTH, sq.size() == 0,
                  hq.size() == DEPTH, hq.size() == 0};
      exp_sv   = 1;
      m_hovf   = (m_hovf && !st_hs) || (stall_run >= 256);
      m_sovf   = (m_sovf && !st_hs) || s_drop;

      if (s_pop) void'(hq.pop_front());
      if (h_pop) void'(sq.pop_front());
      if (CTRL_VALID_I && CTRL_I[0]) hq.delete();
      else if (h_push) hq.push_back(HDATA_I);
      if (CTRL_VALID_I && CTRL_I[1]) sq.delete();
      else if (s_push) sq.push_back(SOC_DATA_I);
      if (CTRL_VALID_I) begin
        m_drop = CTRL_I[2];
        m_en   = CTRL_I[3];
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK_I);
      #1;
    end
  endtask

  task automatic idle();
    CTRL_VALID_I = 0; HDATA_VALID_I = 0; HDATA_READY_I = 0;
    SOC_READY_I = 0; SOC_VALID_I = 0; STATUS_READY_I = 0;
  endtask

  task automatic ctrl(input logic [7:0] v);
    CTRL_VALID_I = 1; CTRL_I = v;
    cyc();
    CTRL_VALID_I = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    RST_I = 0;
    chk("status_valid_before_edge", STATUS_VALID_O, 0);
    cyc();
    chk("status_valid_after_release", STATUS_VALID_O, 1);
    chk("status_reset_value", STATUS_O, 8'h05);

    // Basic host -> SoC transfer
    ctrl(8'h08);
    for (int i = 1; i <= 3; i++) begin
      HDATA_VALID_I = 1; HDATA_I = 32'hA5A5_0000 + i;
      cyc();
      if (i == 1) chk("t1_first_word", SOC_DATA_O, 32'hA5A5_0001);
    end
    HDATA_VALID_I = 0;
    SOC_READY_I = 1; cyc(3); SOC_READY_I = 0;
    cyc(2);
    chk("t1_status_end", STATUS_O, 8'h45);

    // SoC disabled: h2s fills, then the stall watchdog fires
    ctrl(8'h00);
    for (int i = 0; i < 8; i++) begin
      HDATA_VALID_I = 1; HDATA_I = 32'h1000_0000 + i;
      cyc();
    end
    chk("t2_hready_low", HDATA_READY_O, 0);
    chk("t2_soc_valid_low", SOC_VALID_O, 0);
    cyc();
    chk("t2_status_h2s_full", STATUS_O[1], 1);
    cyc(258);
    chk("t2_h2s_ovf", STATUS_O[4], 1);
    HDATA_VALID_I = 0;
    ctrl(8'h08);
    SOC_READY_I = 1; cyc(9); SOC_READY_I = 0;

    // Drop mode overflow on s2h
    ctrl(8'h0C);
    for (int i = 0; i < 8; i++) begin
      SOC_VALID_I = 1; SOC_DATA_I = 32'h5000_0000 + i;
      cyc();
    end
    SOC_DATA_I = 32'hDEAD_BEEF;
    chk("t3_drop_ready", SOC_READY_O, 1);
    cyc();
    SOC_VALID_I = 0;
    cyc(2);
    chk("t3_s2h_ovf", STATUS_O[5], 1);
    for (int i = 0; i < 8; i++) begin
      chk("t3_pop_word", HDATA_O, 32'h5000_0000 + i);
      HDATA_READY_I = 1;
      cyc();
    end
    HDATA_READY_I = 0;
    chk("t3_s2h_drained", HDATA_VALID_O, 0);
    STATUS_READY_I = 1; cyc(); STATUS_READY_I = 0;
    cyc(2);
    chk("t3_ovf_cleared", STATUS_O[5:4], 0);

    // Flush s2h on the same edge as a SoC push and a host pop
    ctrl(8'h08);
    for (int i = 0; i < 3; i++) begin
      SOC_VALID_I = 1; SOC_DATA_I = 32'h3000_0000 + i;
      cyc();
    end
    CTRL_VALID_I = 1; CTRL_I = 8'h0A;
    SOC_VALID_I = 1; SOC_DATA_I = 32'h3000_00FF; HDATA_READY_I = 1;
    chk("t4_popped_head", HDATA_O, 32'h3000_0000);
    cyc();
    idle();
    chk("t4_flushed_valid", HDATA_VALID_O, 0);
    cyc();
    chk("t4_status_s2h_empty", STATUS_O[2], 1);

    // Wrap-around: single-entry pairs with random gaps
    for (int i = 0; i < 20; i++) begin
      HDATA_VALID_I = 1; HDATA_I = $urandom;
      cyc();
      HDATA_VALID_I = 0;
      cyc($urandom_range(0, 3));
      SOC_READY_I = 1;
      cyc();
      SOC_READY_I = 0;
    end

    // Random traffic with alternating fill/drain bias and occasional control
    for (int c = 0; c < 400; c++) begin
      int hi, lo;
      hi = ((c / 100) % 2 == 0) ? 3 : 1;
      lo = ((c / 100) % 2 == 0) ? 1 : 3;
      HDATA_VALID_I  = ($urandom_range(0, 3) < hi);
      HDATA_I        = $urandom;
      SOC_READY_I    = ($urandom_range(0, 3) < lo);
      SOC_VALID_I    = ($urandom_range(0, 3) < hi);
      SOC_DATA_I     = $urandom;
      HDATA_READY_I  = ($urandom_range(0, 3) < lo);
      STATUS_READY_I = ($urandom_range(0, 15) == 0);
      CTRL_VALID_I   = ($urandom_range(0, 47) == 0);
      CTRL_I         = {4'h0, 1'b1, 1'(c >= 200), 2'($urandom_range(0, 3))};
      cyc();
    end
    idle();

    // Asynchronous reset with words queued
    ctrl(8'h0B);
    for (int i = 0; i < 5; i++) begin
      HDATA_VALID_I = 1; HDATA_I = 32'h6000_0000 + i;
      cyc();
    end
    HDATA_VALID_I = 0;
    chk("t6_soc_valid_before", SOC_VALID_O, 1);
    #2;
    RST_I = 1;
    #1;
    chk("t6_rst_soc_valid", SOC_VALID_O, 0);
    chk("t6_rst_soc_data", SOC_DATA_O, 0);
    chk("t6_rst_hready", HDATA_READY_O, 0);
    chk("t6_rst_status", STATUS_O, 0);
    chk("t6_rst_status_valid", STATUS_VALID_O, 0);
    cyc(2);
    RST_I = 0;
    cyc(2);
    chk("t6_s2h_empty", HDATA_VALID_O, 0);
    chk("t6_status_after", STATUS_O, 8'h05);
    ctrl(8'h08);
    chk("t6_h2s_empty", SOC_VALID_O, 0);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
